// File: rtl/seq_player.sv
// Pattern-table stimulus sequencer with loop, one-shot, manual-step and hold modes.
// Define SEQ_LOAD_EN to make the table writable through the load_* port while not running.
module seq_player #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STEP_DIV = 25_000_000
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     step,
  input  logic [DATA_W-1:0]        manual_in,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     tick,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(STEP_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tick_q, busy_q, done_q, step_q;

  logic              cnt_last, addr_last, adv;
  logic [ADDR_W-1:0] addr_inc;

  always_comb begin
    cnt_last  = (cnt_q == CNT_W'(STEP_DIV - 1));
    addr_last = (addr_q == ADDR_W'(DEPTH - 1));
    addr_inc  = addr_last ? '0 : addr_q + 1'b1;
    adv       = 1'b0;
    if (state_q == StRun) begin
      unique case (mode)
        2'b00, 2'b01: adv = cnt_last;
        2'b10:        adv = step & ~step_q;
        default:      adv = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q <= step;
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
          end
        end
        StRun: begin
          // Dropping enable beats a coincident advance: no tick, straight to IDLE.
          if (!enable) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
          end else begin
            if (mode == 2'b00 || mode == 2'b01) begin
              cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            end
            if (adv) begin
              tick_q <= 1'b1;
              if (mode == 2'b01 && addr_last) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                addr_q <= addr_inc;
              end
            end
          end
        end
        StDone: begin
          if (!enable) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            addr_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr = addr_q;
  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SEQ_LOAD_EN
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] table_q [DEPTH];

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= DATA_W'(i);
      end
    end else if (load_we && state_q != StRun && {1'b0, load_addr} < DepthLim) begin
      table_q[load_addr] <= load_data;
    end
  end

  assign out_data = enable ? table_q[addr_q] : manual_in;
`else
  // Without loading the table is the identity, so the entry is just the index.
  logic unused_load;
  assign unused_load = ^{load_we, load_addr, load_data};

  assign out_data = enable ? DATA_W'(addr_q) : manual_in;
`endif

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player (DATA_W=8, DEPTH=4, STEP_DIV=4); table-load checks
// follow the SEQ_LOAD_EN build option.
module tb_seq_player;

  logic       clock, aclr, enable, step, load_we, tick, busy, done;
  logic [1:0] mode, load_addr, addr;
  logic [7:0] manual_in, load_data, out_data;

  int checks = 0;
  int errors = 0;

  seq_player #(.DATA_W(8), .DEPTH(4), .STEP_DIV(4)) dut (
    .clock(clock), .aclr(aclr), .enable(enable), .mode(mode), .step(step),
    .manual_in(manual_in), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .out_data(out_data), .addr(addr), .tick(tick),
    .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b1; enable = 1'b0; mode = 2'b00; step = 1'b0;
    manual_in = 8'hA5; load_we = 1'b0; load_addr = 2'd0; load_data = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", addr); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL reset_pass: got %0h want a5", out_data); end
    aclr = 1'b0;
    cyc();
    manual_in = 8'h5A;
    #1;
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL pass_through: got %0h want 5a", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", busy); end
    manual_in = 8'hA5;
  endtask

  task automatic test_loop();
    logic [1:0] ea;
    mode = 2'b00; enable = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy: got %0b want 1", busy); end
    for (int k = 1; k <= 16; k++) begin
      cyc();
      ea = 2'((k / 4) % 4);
      checks++; if (tick !== (k % 4 == 0)) begin errors++; $display("FAIL loop_tick k=%0d: got %0b", k, tick); end
      checks++; if (addr !== ea) begin errors++; $display("FAIL loop_addr k=%0d: got %0d want %0d", k, addr, ea); end
      checks++; if (out_data !== {6'd0, ea}) begin errors++; $display("FAIL loop_data k=%0d: got %0h want %0h", k, out_data, ea); end
    end
    enable = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0 || addr !== 2'd0) begin errors++; $display("FAIL loop_exit: busy %0b addr %0d want 0 0", busy, addr); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL loop_exit_data: got %0h want a5", out_data); end
  endtask

  task automatic test_oneshot();
    logic [1:0] ea;
    mode = 2'b01; enable = 1'b1;
    cyc();
    for (int k = 1; k <= 19; k++) begin
      cyc();
      ea = (k >= 12) ? 2'd3 : 2'(k / 4);
      checks++; if (tick !== (k == 4 || k == 8 || k == 12 || k == 16)) begin errors++; $display("FAIL os_tick k=%0d: got %0b", k, tick); end
      checks++; if (addr !== ea) begin errors++; $display("FAIL os_addr k=%0d: got %0d want %0d", k, addr, ea); end
      checks++; if (done !== (k >= 16)) begin errors++; $display("FAIL os_done k=%0d: got %0b", k, done); end
      checks++; if (busy !== (k < 16)) begin errors++; $display("FAIL os_busy k=%0d: got %0b", k, busy); end
    end
    checks++; if (out_data !== 8'h03) begin errors++; $display("FAIL os_done_data: got %0h want 03", out_data); end
    enable = 1'b0;
    cyc();
    checks++; if (done !== 1'b0 || addr !== 2'd0) begin errors++; $display("FAIL os_exit: done %0b addr %0d want 0 0", done, addr); end
  endtask

  task automatic test_manual();
    mode = 2'b10; enable = 1'b1; step = 1'b0;
    cyc();
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (addr !== 2'd1) begin errors++; $display("FAIL man_hold_addr i=%0d: got %0d want 1", i, addr); end
      checks++; if (tick !== (i == 0)) begin errors++; $display("FAIL man_hold_tick i=%0d: got %0b", i, tick); end
    end
    step = 1'b0;
    repeat (3) cyc();
    checks++; if (addr !== 2'd1 || tick !== 1'b0) begin errors++; $display("FAIL man_low: addr %0d tick %0b want 1 0", addr, tick); end
    step = 1'b1;
    cyc();
    checks++; if (addr !== 2'd2 || tick !== 1'b1) begin errors++; $display("FAIL man_second: addr %0d tick %0b want 2 1", addr, tick); end
    step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (addr !== 2'd2 || tick !== 1'b0) begin errors++; $display("FAIL man_no_auto i=%0d: addr %0d tick %0b", i, addr, tick); end
    end
    enable = 1'b0;
    cyc();
    checks++; if (addr !== 2'd0) begin errors++; $display("FAIL man_exit: got %0d want 0", addr); end
  endtask

  task automatic test_hold();
    mode = 2'b00; enable = 1'b1;
    cyc();
    repeat (2) cyc();
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (addr !== 2'd0 || tick !== 1'b0) begin errors++; $display("FAIL hold_frozen i=%0d: addr %0d tick %0b", i, addr, tick); end
    end
    mode = 2'b00;
    cyc();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_resume_early: got %0b want 0", tick); end
    cyc();
    checks++; if (tick !== 1'b1 || addr !== 2'd1) begin errors++; $display("FAIL hold_resume: tick %0b addr %0d want 1 1", tick, addr); end
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_load();
    logic [7:0] exp_t2;
    logic [1:0] ea;
    logic [7:0] ed;
`ifdef SEQ_LOAD_EN
    exp_t2 = 8'h3C;
`else
    exp_t2 = 8'h02;
`endif
    load_we = 1'b1; load_addr = 2'd2; load_data = 8'h3C;
    cyc();
    load_we = 1'b0; load_data = 8'hFF;
    mode = 2'b00; enable = 1'b1;
    cyc();
    for (int k = 1; k <= 24; k++) begin
      load_we = (k == 10);
      cyc();
      ea = 2'((k / 4) % 4);
      ed = (ea == 2'd2) ? exp_t2 : {6'd0, ea};
      checks++; if (out_data !== ed) begin errors++; $display("FAIL load_data k=%0d: got %0h want %0h", k, out_data, ed); end
    end
    load_we = 1'b0;
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_aclr();
    mode = 2'b00; enable = 1'b1;
    cyc();
    repeat (8) cyc();
    checks++; if (addr !== 2'd2 || tick !== 1'b1) begin errors++; $display("FAIL aclr_pre: addr %0d tick %0b want 2 1", addr, tick); end
    #2 aclr = 1'b1;
    #1;
    checks++; if (addr !== 2'd0 || busy !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL aclr_async: addr %0d busy %0b tick %0b want 0 0 0", addr, busy, tick); end
    aclr = 1'b0;
    cyc();
    repeat (8) cyc();
    checks++; if (addr !== 2'd2 || out_data !== 8'h02) begin errors++; $display("FAIL aclr_table: addr %0d data %0h want 2 02", addr, out_data); end
    repeat (3) cyc();
    enable = 1'b0;
    cyc();
    checks++; if (tick !== 1'b0 || busy !== 1'b0 || addr !== 2'd0) begin errors++; $display("FAIL en_vs_adv: tick %0b busy %0b addr %0d want 0 0 0", tick, busy, addr); end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++; if (tick !== (k == 4) || addr !== ((k == 4) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL b2b k=%0d: tick %0b addr %0d", k, tick, addr); end
    end
    enable = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_manual();
    test_hold();
    test_load();
    test_aclr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
